// File: rtl/muldiv_if.sv
// muldiv_if: handshake and result bundle between the E stage and the iterative mult/div unit
interface muldiv_if #(parameter int W = 32);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  modport master (output start, op, a, b, cancel, input stall, busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output stall, busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiply / restoring divide, BPC result bits per cycle
module muldiv_iter #(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave io
);
  localparam int N  = W / BPC;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d, step, prod;
  logic [W-1:0]   opr_q, opr_d, hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   ma, mb, rem, quo, rres, qres;
  logic [W+BPC-1:0] msum;
  logic [W:0]     sh, diff;
  logic           div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic           done_q, done_d, busy_q, busy_d, sa, sb;

  assign io.stall = io.start & ~done_q & ~io.cancel;
  assign io.busy  = busy_q;
  assign io.done  = done_q;
  assign io.hi    = hi_q;
  assign io.lo    = lo_q;

  // opr holds |multiplicand| or |divisor|; acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sa   = ~io.op[0] & io.a[W-1];
    sb   = ~io.op[0] & io.b[W-1];
    ma   = sa ? -io.a : io.a;
    mb   = sb ? -io.b : io.b;
    msum = {{BPC{1'b0}}, acc_q[2*W-1:W]} + {{BPC{1'b0}}, opr_q} * {{W{1'b0}}, acc_q[BPC-1:0]};
    rem  = acc_q[2*W-1:W];
    quo  = acc_q[W-1:0];
    sh   = '0;
    diff = '0;
    // remainder stays below the divisor, so diff[W] is exactly the borrow
    for (int k = 0; k < BPC; k++) begin
      sh   = {rem, quo[W-1]};
      diff = sh - {1'b0, opr_q};
      quo  = {quo[W-2:0], ~diff[W]};
      rem  = diff[W] ? sh[W-1:0] : diff[W-1:0];
    end
    step = div_q ? {rem, quo} : {msum, acc_q[W-1:BPC]};
    prod = neg_q ? -step : step;
    qres = neg_q ? -quo : quo;
    rres = rneg_q ? -rem : rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opr_d   = opr_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (io.cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (io.start) begin
          div_d  = io.op[1];
          neg_d  = sa ^ sb;
          rneg_d = sa;
          if (io.op[1] && io.b == '0) begin
            state_d = DONE;
            hi_d    = io.a;
            lo_d    = '1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(N);
            opr_d   = io.op[1] ? mb : ma;
            acc_d   = {{W{1'b0}}, io.op[1] ? ma : mb};
          end
        end
        CALC: begin
          acc_d = step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            hi_d    = div_q ? rres : prod[2*W-1:W];
            lo_d    = div_q ? qres : prod[W-1:0];
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opr_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
endmodule
